// File: rtl/fp_add_seq.sv
// Self-sequenced floating-point adder/subtractor (flush-to-zero, round-to-nearest-even).
// The caller raises start with the operands and waits for the one-cycle done pulse.
module fp_add_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     operando_a,
  input  logic [EXP_W+MAN_W:0]     operando_b,
  output logic                     busy,
  output logic                     done,
  output logic [EXP_W+MAN_W:0]     resultado,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int FW = MAN_W + 4;  // hidden, fraction, guard, round, sticky
  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, FIN} state_t;

  state_t           state;
  logic [W-1:0]     a_r, b_r, res_pend;
  logic             sub_r, sx, eff_sub;
  logic [EXP_W:0]   ex, ey;
  logic [FW-1:0]    mx, my;
  logic [FW:0]      s;

  // Operand decode
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_ge_b;
  logic [FW-1:0]      siga, sigb;

  assign sa     = a_r[W-1];
  assign sb     = b_r[W-1] ^ sub_r;
  assign ea     = a_r[W-2:MAN_W];
  assign eb     = b_r[W-2:MAN_W];
  assign fa     = a_r[MAN_W-1:0];
  assign fb     = b_r[MAN_W-1:0];
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_ge_b = {ea, fa} >= {eb, fb};
  assign siga   = a_zero ? '0 : {1'b1, fa, 3'b000};
  assign sigb   = b_zero ? '0 : {1'b1, fb, 3'b000};

  logic         spec_hit;
  logic [W-1:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
      spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (a_inf)
      spec_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_inf)
      spec_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero && b_zero)
      spec_res = {sa & sb, {(W-1){1'b0}}};
    else
      spec_hit = 1'b0;
  end

  // Alignment shifter with sticky collection
  logic [31:0]   d;
  logic [FW-1:0] sh, lost_mask, aligned;
  logic          sh_st;

  assign d = 32'(ex) - 32'(ey);

  always_comb begin
    sh        = '0;
    lost_mask = '0;
    sh_st     = |my;
    if (d < 32'(FW)) begin
      sh        = my >> d;
      lost_mask = ~({FW{1'b1}} << d);
      sh_st     = |(my & lost_mask);
    end
    aligned = {sh[FW-1:1], sh[0] | sh_st};
  end

  logic [FW:0] sum;
  assign sum = eff_sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});

  // Rounding
  logic [MAN_W:0]   mant;
  logic [MAN_W+1:0] rnd;
  logic             inc, ovf_r;
  logic [EXP_W:0]   e_r;
  logic [MAN_W-1:0] frac_r;

  assign mant   = s[FW-1:3];
  assign inc    = s[2] & (s[1] | s[0] | mant[0]);
  assign rnd    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, inc};
  assign e_r    = rnd[MAN_W+1] ? ex + 1'b1 : ex;
  assign frac_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
  assign ovf_r  = e_r >= EMAX;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      sx        <= 1'b0;
      eff_sub   <= 1'b0;
      ex        <= '0;
      ey        <= '0;
      mx        <= '0;
      my        <= '0;
      s         <= '0;
      res_pend  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r   <= operando_a;
          b_r   <= operando_b;
          sub_r <= op_sub;
          busy  <= 1'b1;
          state <= UNPACK;
        end
        UNPACK: begin
          if (spec_hit) begin
            res_pend <= spec_res;
            state    <= FIN;
          end else begin
            sx      <= a_ge_b ? sa : sb;
            eff_sub <= sa ^ sb;
            ex      <= {1'b0, a_ge_b ? ea : eb};
            ey      <= {1'b0, a_ge_b ? eb : ea};
            mx      <= a_ge_b ? siga : sigb;
            my      <= a_ge_b ? sigb : siga;
            state   <= ALIGN;
          end
        end
        ALIGN: begin
          my    <= aligned;
          state <= ADD;
        end
        ADD: begin
          if (sum == '0) begin
            res_pend <= '0;
            state    <= FIN;
          end else begin
            s     <= sum;
            state <= NORM;
          end
        end
        NORM: begin
          if (s[FW]) begin
            s     <= {1'b0, s[FW:2], s[1] | s[0]};
            ex    <= ex + 1'b1;
            state <= ROUND;
          end else if (s[FW-1]) begin
            state <= ROUND;
          end else if (ex == EONE) begin
            // The next shift would need a subnormal exponent: flush.
            resultado <= {sx, {(W-1){1'b0}}};
            overflow  <= 1'b0;
            underflow <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            s  <= s << 1;
            ex <= ex - 1'b1;
          end
        end
        ROUND: begin
          resultado <= ovf_r ? {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {sx, e_r[EXP_W-1:0], frac_r};
          overflow  <= ovf_r;
          underflow <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        FIN: begin
          // Holding one cycle keeps resultado stable until done fires.
          resultado <= res_pend;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: binary32 instance plus a half-precision rebuild.
module tb_fp_add_seq;
  logic        clock = 1'b0;
  logic        reset, start, op_sub;
  logic [31:0] a, b, res;
  logic        busy, done, ovf, unf;
  logic        start16, busy16, done16, ovf16, unf16;
  logic [15:0] a16, b16, res16;
  int total = 0;
  int bad   = 0;

  fp_add_seq dut (
    .clock(clock), .reset(reset), .start(start), .op_sub(op_sub),
    .operando_a(a), .operando_b(b), .busy(busy), .done(done),
    .resultado(res), .overflow(ovf), .underflow(unf)
  );

  fp_add_seq #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .op_sub(1'b0),
    .operando_a(a16), .operando_b(b16), .busy(busy16), .done(done16),
    .resultado(res16), .overflow(ovf16), .underflow(unf16)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                        input logic sub, input logic [31:0] want, input int lat,
                        input logic wo, input logic wu);
    int  n;
    logic seen;
    @(negedge clock);
    a = xa; b = xb; op_sub = sub; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clock);
      #1;
      n++;
      if (n == 1) check({tag, "/busy"}, busy, 1'b1);
      if (done) seen = 1'b1;
    end
    check({tag, "/lat"}, n, lat);
    check({tag, "/res"}, res, want);
    check({tag, "/ovf"}, ovf, wo);
    check({tag, "/unf"}, unf, wu);
  endtask

  initial begin
    int nd, lat;
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    #12;
    check("rst/busy", busy, 1'b0);
    check("rst/done", done, 1'b0);
    check("rst/res", res, 32'h0);
    check("rst/ovf", ovf, 1'b0);
    check("rst/unf", unf, 1'b0);
    @(negedge clock) reset = 1'b0;

    run_op("add",     32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 5, 1'b0, 1'b0);
    run_op("mix",     32'h3FA24DD3, 32'h401D2F1B, 1'b0, 32'h406E5604, 5, 1'b0, 1'b0);
    run_op("mix_sw",  32'h401D2F1B, 32'h3FA24DD3, 1'b0, 32'h406E5604, 5, 1'b0, 1'b0);
    run_op("tie",     32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 5, 1'b0, 1'b0);
    run_op("above",   32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 5, 1'b0, 1'b0);
    run_op("cancel",  32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 29, 1'b0, 1'b0);
    run_op("negres",  32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 6, 1'b0, 1'b0);
    run_op("zero",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4, 1'b0, 1'b0);
    run_op("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 5, 1'b1, 1'b0);
    run_op("infnan",  32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 2, 1'b0, 1'b0);
    run_op("qnan",    32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 2, 1'b0, 1'b0);
    run_op("negzero", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 2, 1'b0, 1'b0);
    run_op("unf",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4, 1'b0, 1'b1);

    // start while busy must be ignored
    @(negedge clock);
    a = 32'h3FC00000; b = 32'h3F000000; op_sub = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    nd = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i == 2) begin
        a = 32'h7F800000; b = 32'hFF800000; start = 1'b1;
      end else start = 1'b0;
      @(posedge clock);
      #1;
      if (done) begin
        nd++;
        if (lat == 0) lat = i;
      end
    end
    start = 1'b0;
    check("ign/ndone", nd, 1);
    check("ign/lat", lat, 5);
    check("ign/res", res, 32'h40000000);

    // reset in the middle of normalisation
    @(negedge clock);
    a = 32'h3F800000; b = 32'h3F7FFFFF; op_sub = 1'b1; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #1 check("mid/busy_pre", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid/busy", busy, 1'b0);
    check("mid/res", res, 32'h0);
    check("mid/done", done, 1'b0);
    @(negedge clock) reset = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (done) nd++;
    end
    check("mid/nodone", nd, 0);
    run_op("after", 32'h3FC00000, 32'h3F000000, 1'b0, 32'h40000000, 5, 1'b0, 1'b0);

    // half-precision rebuild
    @(negedge clock);
    a16 = 16'h3E00; b16 = 16'h3800; start16 = 1'b1;
    @(posedge clock);
    #1 start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50 && lat == 0; i++) begin
      @(posedge clock);
      #1;
      if (done16) lat = i;
    end
    check("h16/lat", lat, 5);
    check("h16/res", res16, 16'h4000);
    check("h16/ovf", ovf16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
- Sequential IEEE-754-style floating-point adder/subtractor with its own internal control FSM.
- Replaces manually driven mux/shift/round control: the caller presents operands plus `start`, and the block pulses `done` with the packed result.
- Exponent and fraction widths are parametrised; the default is binary32.
- Sits beside the existing floating-point datapath as the self-sequenced unit that test benches and higher-level controllers call.

Parameters:
- EXP_W, 8, exponent field width (≥3); bias = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width (≥2); significand is MAN_W+1 bits including the hidden one.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- op_sub, input, 1, 0 = a+b, 1 = a-b (flips sign of b); sampled with start.
- operando_a, input, EXP_W+MAN_W+1, operand A {sign, exp, frac}; sampled with start.
- operando_b, input, EXP_W+MAN_W+1, operand B; sampled with start.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse; resultado valid.
- resultado, output, EXP_W+MAN_W+1, packed result; held until the next done.
- overflow, output, 1, result rounded to infinity from finite inputs; valid with done, held.
- underflow, output, 1, nonzero exact result flushed to zero; valid with done, held.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, resultado=0, overflow=0, underflow=0; internal registers cleared. An in-flight operation is discarded and no done is issued.
- Operand capture: start is honoured only in IDLE. start while busy is ignored; no queueing.
- Subnormal inputs (exp=0) are treated as ±0 (flush-to-zero). No subnormal results are produced.
- FSM states: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE. Each state occupies one cycle except NORM.
- IDLE:
  - On start, register operands and op_sub; next state UNPACK.
- UNPACK:
  - Restore hidden bits.
  - Detect specials; if special, load resultado, pulse done next cycle, return to IDLE.
  - Special results:
    - NaN input → canonical quiet NaN {0, all-ones, 1 followed by zeros}.
    - inf ± inf with opposite effective signs → canonical NaN.
    - Otherwise any inf → that inf.
    - Both zero → +0, or -0 only if both are -0 (after op_sub).
  - Otherwise order operands so the larger magnitude is X; result sign = sign of X.
- ALIGN:
  - Barrel-shift the smaller significand right by the exponent difference d into an extended field of MAN_W+4 bits (hidden, fraction, guard, round, sticky).
  - Sticky = OR of all bits shifted past round.
  - d ≥ MAN_W+3 leaves only sticky.
- ADD:
  - Add or subtract the magnitudes per the effective sign, with one carry bit.
  - Exact zero result → +0, done next cycle.
- NORM:
  - On carry out: shift right 1 (sticky preserved), exponent +1; one cycle.
  - Otherwise shift left 1 bit per cycle, exponent -1 per cycle, until the hidden bit is 1.
  - Exponent reaching 0 during the left shift → result ±0, underflow=1.
  - NORM latency = 1 + k cycles, k = number of left shifts.
- ROUND:
  - Round-to-nearest-even on guard/round/sticky.
  - Mantissa carry-out from rounding → shift right 1, exponent +1 (same cycle).
  - Exponent ≥ all-ones → ±inf, overflow=1.
  - Pack the result; done pulses in the next cycle, with the state back in IDLE.
- Latency, start edge to done high:
  - Normal path: 5 + k cycles; minimum 5.
  - Special path: 2 cycles.
  - Zero-sum path: 4 cycles.
- Back-to-back: start may be asserted in the same cycle done is high; it is accepted (state is IDLE).

Test Plan:
1. Basic add: 0x3FC00000 + 0x3F000000 (1.5+0.5), op_sub=0 → resultado 0x40000000, done exactly 5 cycles after start, overflow=underflow=0.
2. Operand swap, mixed exponents: 0x3FA24DD3 + 0x401D2F1B (1.268+2.456) → 0x406E5604; repeat with the operands swapped → same result.
3. Rounding ties:
   - 0x3F800000 + 0x33800000 (tie) → 0x3F800000 (even).
   - 0x3F800000 + 0x33C00000 (above half) → 0x3F800001.
4. Cancellation: 0x3F800000 - 0x3F7FFFFF (op_sub=1) → 0x33800000 after 24 normalisation steps, done at cycle 29.
   - Separately, 0x3F800000 - 0x3F800000 → 0x00000000, done at cycle 4.
5. Specials and overflow:
   - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow=1.
   - 0x7F800000 + 0xFF800000 → 0x7FC00000 in 2 cycles.
6. Control:
   - start pulsed while busy → ignored; exactly one done.
   - reset asserted mid-NORM → outputs 0 immediately, no done; a new start afterwards completes normally.
   - Rebuild with EXP_W=5, MAN_W=10: 0x3E00 + 0x3800 (1.5+0.5) → 0x4000.
